// File: rtl/sig_deb_multi.sv
// Multi-channel symmetric debouncer: two-flop synchronisers, one shared sample
// prescaler, and a per-channel stability counter that qualifies both edges alike.
module sig_deb_multi #(
  parameter int   CH       = 4,
  parameter int   PRESCALE = 50000,
  parameter int   STABLE_N = 4,
  parameter logic INIT     = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic [CH-1:0] sig_i,
  output logic [CH-1:0] sig_o,
  output logic [CH-1:0] rise_o,
  output logic [CH-1:0] fall_o,
  output logic          tick_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CW = $clog2(STABLE_N + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(STABLE_N - 1);

  logic [CH-1:0] sync1;
  logic [CH-1:0] sync2;
  logic [PW-1:0] presc;
  logic [CW-1:0] cnt [CH];
  logic          tick;

  // Reset is folded in so the tick stays low while the block is held in reset,
  // even with PRESCALE=1 where the idle count already equals the terminal value.
  assign tick   = en_i & rst_n & (presc == PRESC_MAX);
  assign tick_o = tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= {CH{INIT}};
      sync2 <= {CH{INIT}};
    end else begin
      sync1 <= sig_i;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (!en_i || presc == PRESC_MAX) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // A disagreement must persist for STABLE_N ticks; any agreeing tick restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_o  <= {CH{INIT}};
      rise_o <= '0;
      fall_o <= '0;
      for (int i = 0; i < CH; i++) cnt[i] <= '0;
    end else begin
      rise_o <= '0;
      fall_o <= '0;
      for (int i = 0; i < CH; i++) begin
        if (!en_i) begin
          cnt[i] <= '0;
        end else if (tick) begin
          if (sync2[i] == sig_o[i]) begin
            cnt[i] <= '0;
          end else if (cnt[i] == CNT_MAX) begin
            sig_o[i]  <= sync2[i];
            rise_o[i] <= sync2[i];
            fall_o[i] <= ~sync2[i];
            cnt[i]    <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sig_deb_multi.sv
// Scoreboard bench for sig_deb_multi: instance a (PRESCALE=1, STABLE_N=4) and
// instance b (PRESCALE=10, STABLE_N=3) share clock and reset.
`timescale 1ns/1ps
module tb_sig_deb_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_a, en_b;
  logic [3:0] sig_a, sig_b;
  logic [3:0] so_a, ri_a, fa_a, so_b, ri_b, fa_b;
  logic       tk_a, tk_b;

  always #5 clk = ~clk;

  sig_deb_multi #(.CH(4), .PRESCALE(1), .STABLE_N(4), .INIT(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .en_i(en_a), .sig_i(sig_a),
    .sig_o(so_a), .rise_o(ri_a), .fall_o(fa_a), .tick_o(tk_a)
  );

  sig_deb_multi #(.CH(4), .PRESCALE(10), .STABLE_N(3), .INIT(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .en_i(en_b), .sig_i(sig_b),
    .sig_o(so_b), .rise_o(ri_b), .fall_o(fa_b), .tick_o(tk_b)
  );

  typedef struct {
    int         edge_no;
    logic [3:0] sig;
    logic [3:0] rise;
    logic [3:0] fall;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   edge_cnt = 0;
  int   rel_b = 0;

  // edge_cnt equals k between posedge k and posedge k+1
  always @(posedge clk) edge_cnt++;

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pulse(input bit use_b, input int budget, output int ed,
                            output logic [3:0] s, output logic [3:0] r,
                            output logic [3:0] f, output bit got);
    got = 1'b0;
    ed  = -1;
    s   = 'x;
    r   = 'x;
    f   = 'x;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (use_b ? ((ri_b | fa_b) != 4'b0) : ((ri_a | fa_a) != 4'b0)) begin
        got = 1'b1;
        ed  = edge_cnt;
        s   = use_b ? so_b : so_a;
        r   = use_b ? ri_b : ri_a;
        f   = use_b ? fa_b : fa_a;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en_a  = 1'b1;
    en_b  = 1'b1;
    sig_a = 4'b0;
    sig_b = 4'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({so_a, ri_a, fa_a, tk_a, so_b, ri_b, fa_b, tk_b} !== 26'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_state: a sig %b rise %b fall %b tick %b / b sig %b rise %b fall %b tick %b, required all zero",
               so_a, ri_a, fa_a, tk_a, so_b, ri_b, fa_b, tk_b);
    end
    after_edge();
    rst_n = 1'b1;
    rel_b = edge_cnt + 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({so_a, ri_a, fa_a, tk_a} !== 13'b1) begin
        n_bad++;
        $display("[TB] FAIL idle_after_reset: sig %b rise %b fall %b tick %b, required sig 0000 no pulses tick 1",
                 so_a, ri_a, fa_a, tk_a);
      end
    end
  endtask

  task automatic test_prescale();
    exp_t       ex;
    int         ed, k, t;
    logic [3:0] s, r, f;
    bit         got;
    logic       exp_tk;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      exp_tk = (edge_cnt >= rel_b + 8) && (((edge_cnt - rel_b - 8) % 10) == 0);
      n_cmp++;
      if (tk_b !== exp_tk) begin
        n_bad++;
        $display("[TB] FAIL tick_period: edge %0d tick %b, required %b", edge_cnt, tk_b, exp_tk);
      end
    end
    for (int step = 0; step < 2; step++) begin
      after_edge();
      sig_b[2] = (step == 0);
      k = edge_cnt + 1;
      t = rel_b + 9;
      while (t < k + 2) t += 10;
      sb_q.push_back('{t + 20, (step == 0) ? 4'b0100 : 4'b0000,
                       (step == 0) ? 4'b0100 : 4'b0000,
                       (step == 0) ? 4'b0000 : 4'b0100});
      wait_pulse(1'b1, 45, ed, s, r, f, got);
      ex = sb_q.pop_front();
      n_cmp++;
      if (!got || ed !== ex.edge_no || s !== ex.sig || r !== ex.rise || f !== ex.fall) begin
        n_bad++;
        $display("[TB] FAIL prescaled_step%0d: got %b edge %0d sig %b rise %b fall %b, required edge %0d sig %b rise %b fall %b",
                 step, got, ed, s, r, f, ex.edge_no, ex.sig, ex.rise, ex.fall);
      end
    end
  endtask

  task automatic test_edges();
    exp_t       ex;
    int         ed, k;
    logic [3:0] s, r, f;
    bit         got;
    for (int step = 0; step < 2; step++) begin
      after_edge();
      sig_a[0] = (step == 0);
      k = edge_cnt + 1;
      sb_q.push_back('{k + 5, (step == 0) ? 4'b0001 : 4'b0000,
                       (step == 0) ? 4'b0001 : 4'b0000,
                       (step == 0) ? 4'b0000 : 4'b0001});
      wait_pulse(1'b0, 20, ed, s, r, f, got);
      ex = sb_q.pop_front();
      n_cmp++;
      if (!got || ed !== ex.edge_no || s !== ex.sig || r !== ex.rise || f !== ex.fall) begin
        n_bad++;
        $display("[TB] FAIL edge_step%0d: got %b edge %0d sig %b rise %b fall %b, required edge %0d sig %b rise %b fall %b",
                 step, got, ed, s, r, f, ex.edge_no, ex.sig, ex.rise, ex.fall);
      end
      @(negedge clk);
      n_cmp++;
      if ((ri_a | fa_a) !== 4'b0 || so_a !== ex.sig) begin
        n_bad++;
        $display("[TB] FAIL single_pulse%0d: rise %b fall %b sig %b, required no pulse sig %b",
                 step, ri_a, fa_a, so_a, ex.sig);
      end
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic test_glitch();
    exp_t       ex;
    int         ed, k;
    logic [3:0] s, r, f;
    bit         got;
    after_edge();
    sig_a[1] = 1'b1;
    repeat (3) after_edge();
    sig_a[1] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_cmp++;
      if (so_a !== 4'b0 || (ri_a | fa_a) !== 4'b0) begin
        n_bad++;
        $display("[TB] FAIL glitch_3: sig %b rise %b fall %b, required sig 0000 no pulses", so_a, ri_a, fa_a);
      end
    end
    after_edge();
    sig_a[1] = 1'b1;
    k = edge_cnt + 1;
    sb_q.push_back('{k + 5, 4'b0010, 4'b0010, 4'b0000});
    sb_q.push_back('{k + 9, 4'b0000, 4'b0000, 4'b0010});
    repeat (4) after_edge();
    sig_a[1] = 1'b0;
    for (int j = 0; j < 2; j++) begin
      wait_pulse(1'b0, 20, ed, s, r, f, got);
      ex = sb_q.pop_front();
      n_cmp++;
      if (!got || ed !== ex.edge_no || s !== ex.sig || r !== ex.rise || f !== ex.fall) begin
        n_bad++;
        $display("[TB] FAIL glitch_4_ev%0d: got %b edge %0d sig %b rise %b fall %b, required edge %0d sig %b rise %b fall %b",
                 j, got, ed, s, r, f, ex.edge_no, ex.sig, ex.rise, ex.fall);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    exp_t       ex;
    int         ed, k;
    logic [3:0] s, r, f;
    bit         got;
    for (int step = 0; step < 2; step++) begin
      after_edge();
      sig_a = (step == 0) ? 4'b1000 : 4'b0001;
      k = edge_cnt + 1;
      sb_q.push_back('{k + 5, sig_a, (step == 0) ? 4'b1000 : 4'b0001,
                       (step == 0) ? 4'b0000 : 4'b1000});
      wait_pulse(1'b0, 20, ed, s, r, f, got);
      ex = sb_q.pop_front();
      n_cmp++;
      if (!got || ed !== ex.edge_no || s !== ex.sig || r !== ex.rise || f !== ex.fall) begin
        n_bad++;
        $display("[TB] FAIL simultaneous%0d: got %b edge %0d sig %b rise %b fall %b, required edge %0d sig %b rise %b fall %b",
                 step, got, ed, s, r, f, ex.edge_no, ex.sig, ex.rise, ex.fall);
      end
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    exp_t       ex;
    int         ed, r_edge;
    logic [3:0] s, r, f;
    bit         got;
    after_edge();
    sig_a[2] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({so_a, ri_a, fa_a, tk_a} !== 13'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_mid_async: sig %b rise %b fall %b tick %b, required all zero", so_a, ri_a, fa_a, tk_a);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({so_a, ri_a, fa_a} !== 12'b0) begin
        n_bad++;
        $display("[TB] FAIL reset_mid_hold: sig %b rise %b fall %b, required all zero", so_a, ri_a, fa_a);
      end
    end
    after_edge();
    rst_n  = 1'b1;
    r_edge = edge_cnt + 1;
    rel_b  = r_edge;
    sb_q.push_back('{r_edge + 5, 4'b0101, 4'b0101, 4'b0000});
    wait_pulse(1'b0, 20, ed, s, r, f, got);
    ex = sb_q.pop_front();
    n_cmp++;
    if (!got || ed !== ex.edge_no || s !== ex.sig || r !== ex.rise || f !== ex.fall) begin
      n_bad++;
      $display("[TB] FAIL reset_mid_resume: got %b edge %0d sig %b rise %b fall %b, required edge %0d sig %b rise %b fall %b",
               got, ed, s, r, f, ex.edge_no, ex.sig, ex.rise, ex.fall);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_enable_mid();
    exp_t       ex;
    int         ed, e;
    logic [3:0] s, r, f;
    bit         got;
    after_edge();
    sig_a[2] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    en_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (so_a !== 4'b0101 || (ri_a | fa_a) !== 4'b0 || tk_a !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL enable_freeze: sig %b rise %b fall %b tick %b, required sig 0101 no pulses tick 0",
                 so_a, ri_a, fa_a, tk_a);
      end
    end
    after_edge();
    en_a = 1'b1;
    e = edge_cnt + 1;
    sb_q.push_back('{e + 3, 4'b0001, 4'b0000, 4'b0100});
    wait_pulse(1'b0, 20, ed, s, r, f, got);
    ex = sb_q.pop_front();
    n_cmp++;
    if (!got || ed !== ex.edge_no || s !== ex.sig || r !== ex.rise || f !== ex.fall) begin
      n_bad++;
      $display("[TB] FAIL enable_restart: got %b edge %0d sig %b rise %b fall %b, required edge %0d sig %b rise %b fall %b",
               got, ed, s, r, f, ex.edge_no, ex.sig, ex.rise, ex.fall);
    end
  endtask

  initial begin
    test_reset();
    test_prescale();
    test_edges();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    test_enable_mid();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
